// File: rtl/banked_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : banked_mem_responder
// Description : Four-bank interleaved word memory. Accepts one read or write
//               per cycle, bank selected by addr[2:1]. A bank stays occupied
//               for BANK_CYCLES cycles after accepting a request; requests to
//               an occupied bank are stalled. Reads return after 2 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module banked_mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BANK_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              stall,
    output logic [3:0]        busy,
    output logic              err
);

    localparam int                 c_NBANKS   = 4;
    localparam int                 c_IDX_W    = ADDR_W - 1;
    localparam int                 c_WORDS    = 2 ** c_IDX_W;
    localparam int                 c_CNT_W    = $clog2(BANK_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(BANK_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [DATA_W-1:0]  r_mem [c_WORDS];

    logic               w_req;
    logic [1:0]         w_bank;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_accept;
    logic               w_wr_acc;
    logic               w_rd_acc;

    logic               r_s1_valid;
    logic [c_IDX_W-1:0] r_s1_idx;

    // Request decode; a busy bank only stalls a request that is otherwise legal
    assign w_req    = wr | rd;
    assign w_bank   = addr[2:1];
    assign w_idx    = addr[ADDR_W-1:1];
    assign err      = (w_req & addr[0]) | (wr & rd);
    assign stall    = w_req & ~err & busy[w_bank];
    assign w_accept = w_req & ~err & ~stall;
    assign w_wr_acc = w_accept & wr;
    assign w_rd_acc = w_accept & rd;

    // Per-bank occupancy counters; a new accept reloads even if still counting
    generate
        for (genvar b = 0; b < c_NBANKS; b++) begin : g_bank
            logic [c_CNT_W-1:0] r_cnt;

            // Load on accept to this bank, otherwise count down to zero
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_accept && (w_bank == 2'(b))) begin
                    r_cnt <= c_CNT_LOAD;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                end
            end

            assign busy[b] = (r_cnt != '0);
        end
    endgenerate

    // Word array write port; contents deliberately have no reset
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_idx] <= data_in;
        end
    end

    // Read pipe stage 1: capture word index of an accepted read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_idx <= w_idx;
            end
        end
    end

    // Read pipe stage 2: register array data; data_out holds when no read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            data_out <= '0;
        end else begin
            rd_valid <= r_s1_valid;
            if (r_s1_valid) begin
                data_out <= r_mem[r_s1_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_banked_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_banked_mem_responder
// Description : Scoreboard bench for banked_mem_responder. A reference model
//               of bank occupancy and memory contents predicts stall/err/busy
//               every cycle and queues expected read data with its due cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banked_mem_responder;

    localparam int c_BANK_CYCLES = 4;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    banked_mem_responder #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .BANK_CYCLES (c_BANK_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .stall    (stall),
        .busy     (busy),
        .err      (err)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] mm [int];
    int          mcnt [4];
    int          cyc     = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] model_busy();
        logic [3:0] mb;
        for (int b = 0; b < 4; b++) mb[b] = (mcnt[b] != 0);
        return mb;
    endfunction

    // Read-data monitor: pops the scoreboard when data is due
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    check("rd_valid_spurious", 32'(rd_valid), 32'd0);
                end else begin
                    check("rd_due_cycle", 32'(cyc), 32'(sb[0].due));
                    check("rd_data", 32'(data_out), 32'(sb[0].data));
                    void'(sb.pop_front());
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                check("rd_valid_missing", 32'(rd_valid), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    // One bus cycle: drive, check combinational outputs, advance model
    task automatic step(input logic w, input logic r, input logic [15:0] a,
                        input logic [15:0] d, output logic st);
        logic       e, s, acc;
        logic [1:0] b;
        wr = w; rd = r; addr = a; data_in = d;
        #3;
        b   = a[2:1];
        e   = ((w | r) & a[0]) | (w & r);
        s   = (w | r) & ~e & (mcnt[b] != 0);
        acc = (w | r) & ~e & ~s;
        check("err", 32'(err), 32'(e));
        check("stall", 32'(stall), 32'(s));
        check("busy", 32'(busy), 32'(model_busy()));
        st = stall;
        if (acc && r) begin
            if (mm.exists(int'(a[15:1]))) sb.push_back('{cyc + 2, mm[int'(a[15:1])]});
            else sb.push_back('{cyc + 2, 16'hxxxx});
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) if (mcnt[k] != 0) mcnt[k]--;
        if (acc) mcnt[b] = c_BANK_CYCLES - 1;
        if (acc && w) mm[int'(a[15:1])] = d;
    endtask

    task automatic idle(input int n);
        logic st;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, st);
    endtask

    initial begin
        logic        st;
        int          nstall;
        logic [15:0] wdat [4];
        logic [3:0]  bexp [4];
        wdat[0] = 16'hA0A0; wdat[1] = 16'hB1B1; wdat[2] = 16'hC2C2; wdat[3] = 16'hD3D3;
        bexp[0] = 4'b0001;  bexp[1] = 4'b0011;  bexp[2] = 4'b0111;  bexp[3] = 4'b1110;
        for (int k = 0; k < 4; k++) mcnt[k] = 0;

        rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; data_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;

        // Four consecutive writes, one per bank
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 16'(16'h0010 + 2 * i), wdat[i], st);
            check("wr_seq_no_stall", 32'(st), 32'd0);
            #1;
            check("wr_seq_busy", 32'(busy), 32'(bexp[i]));
        end
        idle(4);
        step(1'b1, 1'b0, 16'h0018, 16'hE4E4, st);
        idle(4);

        // Back-to-back reads across banks, data in order
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 16'(16'h0010 + 2 * i), 16'h0000, st);
            check("rd_seq_no_stall", 32'(st), 32'd0);
        end
        idle(5);
        check("data_out_hold", 32'(data_out), 32'hD3D3);
        check("rd_valid_idle", 32'(rd_valid), 32'd0);

        // Same-bank read is stalled until the bank frees
        step(1'b0, 1'b1, 16'h0010, 16'h0000, st);
        nstall = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 16'h0018, 16'h0000, st);
            if (st) nstall++;
            else break;
        end
        check("bank_conflict_stalls", 32'(nstall), 32'd3);
        idle(6);

        // Illegal requests leave state and memory untouched
        step(1'b1, 1'b0, 16'h0020, 16'h5555, st);
        idle(4);
        step(1'b0, 1'b1, 16'h0011, 16'h0000, st);
        check("err_misaligned_rd", 32'(err), 32'd1);
        step(1'b1, 1'b1, 16'h0020, 16'h7777, st);
        check("err_wr_rd", 32'(err), 32'd1);
        step(1'b1, 1'b0, 16'h0021, 16'h9999, st);
        check("err_misaligned_wr_busy", 32'(busy), 32'd0);
        step(1'b0, 1'b1, 16'h0020, 16'h0000, st);
        idle(4);

        // Reset while a read is in flight drops it
        step(1'b0, 1'b1, 16'h0010, 16'h0000, st);
        wr = 1'b0; rd = 1'b0;
        #2 rst = 1'b1;
        sb.delete();
        for (int k = 0; k < 4; k++) mcnt[k] = 0;
        #2;
        check("rst_mid_data_out", 32'(data_out), 32'd0);
        check("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);
        check("rst_after_busy", 32'(busy), 32'd0);
        check("rst_after_data_out", 32'(data_out), 32'd0);

        // Write then read the same word; early read sees stall
        step(1'b1, 1'b0, 16'h0100, 16'h1234, st);
        step(1'b0, 1'b1, 16'h0100, 16'h0000, st);
        check("raw_early_stall", 32'(st), 32'd1);
        for (int i = 0; i < 10 && st; i++) step(1'b0, 1'b1, 16'h0100, 16'h0000, st);
        idle(4);
        check("raw_data_out", 32'(data_out), 32'h1234);

        idle(4);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
